// File: rtl/morse_pkg.sv
// ---------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse keyer: FSM state encoding, element and
// gap durations in Morse units, and a helper that turns a reading-order
// dot/dash sequence into the first-element-in-bit-0 pattern used by the FSM.
// ---------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_ELEM_GAP,
        S_CHAR_GAP,
        S_WORD_GAP
    } state_t;

    localparam int DOT_UNITS        = 1;
    localparam int DASH_UNITS       = 3;
    localparam int ELEM_GAP_UNITS   = 1;
    localparam int CHAR_GAP_UNITS   = 3;
    localparam int WORD_EXTRA_UNITS = 4;
    localparam int MAX_ELEMS        = 6;

    // seq holds the code in reading order: its bit (len-1) is the first
    // element. The returned pattern has the first element in bit 0.
    // 1 = dash, 0 = dot.
    function automatic logic [MAX_ELEMS-1:0] seq_to_pat(
        input logic [2:0]           len,
        input logic [MAX_ELEMS-1:0] seq
    );
        logic [MAX_ELEMS-1:0] pat;
        logic [2:0]           j;
        pat = '0;
        for (int i = 0; i < MAX_ELEMS; i++) begin
            if (i < int'(len)) begin
                j      = 3'(int'(len) - 1 - i);
                pat[i] = seq[j];
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/morse_lut.sv
// ---------------------------------------------------------------------------
// morse_lut
// Combinational ASCII -> Morse code lookup with lowercase folding.
//   i_char     : ASCII character (only codes < 256 can be supported)
//   o_valid    : character has a Morse code (letters, digits, optional punct)
//   o_is_space : character is 0x20 (word gap, no marks)
//   o_len      : number of elements, 1..6 (0 when not valid)
//   o_pat      : element pattern, bit 0 first, 1 = dash
// Build option: define MORSE_PUNCT_EN to add . , ? / to the table.
// ---------------------------------------------------------------------------
module morse_lut
    import morse_pkg::*;
#(
    parameter int WORD_BITS = 8
) (
    input  logic [WORD_BITS-1:0] i_char,
    output logic                 o_valid,
    output logic                 o_is_space,
    output logic [2:0]           o_len,
    output logic [5:0]           o_pat
);

    logic                 w_hi_zero;
    logic [7:0]           w_lo;
    logic [7:0]           w_fold;
    logic [2:0]           w_len;
    logic [5:0]           w_seq;

    assign w_hi_zero = ((i_char >> 8) == '0);
    assign w_lo      = i_char[7:0];
    assign w_fold    = (w_lo >= 8'h61 && w_lo <= 8'h7A) ? (w_lo - 8'h20) : w_lo;

    // Entries are {len, sequence in reading order}; len 0 means unsupported.
    always_comb begin
        w_len = 3'd0;
        w_seq = 6'b0;
        case (w_fold)
            8'h41: {w_len, w_seq} = {3'd2, 6'b01};      // A .-
            8'h42: {w_len, w_seq} = {3'd4, 6'b1000};    // B -...
            8'h43: {w_len, w_seq} = {3'd4, 6'b1010};    // C -.-.
            8'h44: {w_len, w_seq} = {3'd3, 6'b100};     // D -..
            8'h45: {w_len, w_seq} = {3'd1, 6'b0};       // E .
            8'h46: {w_len, w_seq} = {3'd4, 6'b0010};    // F ..-.
            8'h47: {w_len, w_seq} = {3'd3, 6'b110};     // G --.
            8'h48: {w_len, w_seq} = {3'd4, 6'b0000};    // H ....
            8'h49: {w_len, w_seq} = {3'd2, 6'b00};      // I ..
            8'h4A: {w_len, w_seq} = {3'd4, 6'b0111};    // J .---
            8'h4B: {w_len, w_seq} = {3'd3, 6'b101};     // K -.-
            8'h4C: {w_len, w_seq} = {3'd4, 6'b0100};    // L .-..
            8'h4D: {w_len, w_seq} = {3'd2, 6'b11};      // M --
            8'h4E: {w_len, w_seq} = {3'd2, 6'b10};      // N -.
            8'h4F: {w_len, w_seq} = {3'd3, 6'b111};     // O ---
            8'h50: {w_len, w_seq} = {3'd4, 6'b0110};    // P .--.
            8'h51: {w_len, w_seq} = {3'd4, 6'b1101};    // Q --.-
            8'h52: {w_len, w_seq} = {3'd3, 6'b010};     // R .-.
            8'h53: {w_len, w_seq} = {3'd3, 6'b000};     // S ...
            8'h54: {w_len, w_seq} = {3'd1, 6'b1};       // T -
            8'h55: {w_len, w_seq} = {3'd3, 6'b001};     // U ..-
            8'h56: {w_len, w_seq} = {3'd4, 6'b0001};    // V ...-
            8'h57: {w_len, w_seq} = {3'd3, 6'b011};     // W .--
            8'h58: {w_len, w_seq} = {3'd4, 6'b1001};    // X -..-
            8'h59: {w_len, w_seq} = {3'd4, 6'b1011};    // Y -.--
            8'h5A: {w_len, w_seq} = {3'd4, 6'b1100};    // Z --..
            8'h30: {w_len, w_seq} = {3'd5, 6'b11111};   // 0
            8'h31: {w_len, w_seq} = {3'd5, 6'b01111};   // 1
            8'h32: {w_len, w_seq} = {3'd5, 6'b00111};   // 2
            8'h33: {w_len, w_seq} = {3'd5, 6'b00011};   // 3
            8'h34: {w_len, w_seq} = {3'd5, 6'b00001};   // 4
            8'h35: {w_len, w_seq} = {3'd5, 6'b00000};   // 5
            8'h36: {w_len, w_seq} = {3'd5, 6'b10000};   // 6
            8'h37: {w_len, w_seq} = {3'd5, 6'b11000};   // 7
            8'h38: {w_len, w_seq} = {3'd5, 6'b11100};   // 8
            8'h39: {w_len, w_seq} = {3'd5, 6'b11110};   // 9
`ifdef MORSE_PUNCT_EN
            8'h2E: {w_len, w_seq} = {3'd6, 6'b010101};  // . .-.-.-
            8'h2C: {w_len, w_seq} = {3'd6, 6'b110011};  // , --..--
            8'h3F: {w_len, w_seq} = {3'd6, 6'b001100};  // ? ..--..
            8'h2F: {w_len, w_seq} = {3'd5, 6'b10010};   // / -..-.
`endif
            default: {w_len, w_seq} = {3'd0, 6'b0};
        endcase
    end

    assign o_valid    = w_hi_zero && (w_len != 3'd0);
    assign o_is_space = w_hi_zero && (w_lo == 8'h20);
    assign o_len      = o_valid ? w_len : 3'd0;
    assign o_pat      = o_valid ? seq_to_pat(w_len, w_seq) : 6'b0;

endmodule

// File: rtl/morse_encoder.sv
// ---------------------------------------------------------------------------
// morse_encoder
// Morse keyer fed from a UART RX FIFO. Pops one ASCII character at a time
// (valid/ready) and keys morse_o with standard timing paced by one unit
// counter of UNIT_LIMIT cycles.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   data_i         : ASCII character from the FIFO
//   data_valid_i   : FIFO not empty
//   ready_o        : accepting this cycle (FIFO pop = valid & ready)
//   morse_o        : key line, 1 = tone
//   busy_o         : FSM not idle
//   done_o         : 1-cycle pulse on the last cycle of a character/space
//   err_o          : 1-cycle pulse after an unsupported character is popped
// Build option: MORSE_PUNCT_EN (handled inside morse_lut).
// ---------------------------------------------------------------------------
module morse_encoder
    import morse_pkg::*;
#(
    parameter int WORD_BITS  = 8,
    parameter int UNIT_LIMIT = 6_000_000,
    parameter int UNIT_BITS  = 23
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [WORD_BITS-1:0] data_i,
    input  logic                 data_valid_i,
    output logic                 ready_o,
    output logic                 morse_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam logic [UNIT_BITS-1:0] CNT_LAST = UNIT_BITS'(UNIT_LIMIT - 1);
    localparam logic [UNIT_BITS-1:0] CNT_PEN  = UNIT_BITS'(UNIT_LIMIT - 2);

    state_t               r_state, w_next_state;
    logic [UNIT_BITS-1:0] r_cnt, w_cnt_next;
    logic [1:0]           r_unit, w_unit_next;
    logic [1:0]           w_units_m1;
    logic [2:0]           r_idx, w_idx_next;
    logic [2:0]           r_len;
    logic [5:0]           r_pat;
    logic                 r_ready, r_morse, r_busy, r_done, r_err;
    logic                 w_accept, w_unit_end, w_done_next, w_err_next;
    logic                 w_lut_valid, w_lut_space;
    logic [2:0]           w_lut_len;
    logic [5:0]           w_lut_pat;

    morse_lut #(.WORD_BITS(WORD_BITS)) u_lut (
        .i_char     (data_i),
        .o_valid    (w_lut_valid),
        .o_is_space (w_lut_space),
        .o_len      (w_lut_len),
        .o_pat      (w_lut_pat)
    );

    assign w_accept   = data_valid_i && r_ready;
    assign w_unit_end = (r_cnt == CNT_LAST);

    // Duration of the current state, in units minus one.
    always_comb begin
        w_units_m1 = 2'd0;
        case (r_state)
            S_MARK:     w_units_m1 = r_pat[r_idx] ? 2'(DASH_UNITS - 1) : 2'(DOT_UNITS - 1);
            S_ELEM_GAP: w_units_m1 = 2'(ELEM_GAP_UNITS - 1);
            S_CHAR_GAP: w_units_m1 = 2'(CHAR_GAP_UNITS - 1);
            S_WORD_GAP: w_units_m1 = 2'(WORD_EXTRA_UNITS - 1);
            default:    w_units_m1 = 2'd0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_unit_next  = r_unit;
        w_idx_next   = r_idx;
        if (r_state == S_IDLE) begin
            w_cnt_next  = '0;
            w_unit_next = 2'd0;
            if (w_accept) begin
                w_idx_next = 3'd0;
                if (w_lut_valid)
                    w_next_state = S_MARK;
                else if (w_lut_space)
                    w_next_state = S_WORD_GAP;
            end
        end else if (!w_unit_end) begin
            w_cnt_next = r_cnt + 1'b1;
        end else if (r_unit != w_units_m1) begin
            w_cnt_next  = '0;
            w_unit_next = r_unit + 2'd1;
        end else begin
            // Last cycle of the state: counters restart for the next state.
            w_cnt_next  = '0;
            w_unit_next = 2'd0;
            case (r_state)
                S_MARK: begin
                    if (r_idx < (r_len - 3'd1)) begin
                        w_idx_next   = r_idx + 3'd1;
                        w_next_state = S_ELEM_GAP;
                    end else begin
                        w_next_state = S_CHAR_GAP;
                    end
                end
                S_ELEM_GAP: w_next_state = S_MARK;
                default:    w_next_state = S_IDLE;
            endcase
        end
    end

    // Gaps last at least 3 units of >= 2 cycles, so the penultimate cycle
    // is never the entry cycle; flag it so done_o lands on the last cycle.
    assign w_done_next = ((r_state == S_CHAR_GAP) || (r_state == S_WORD_GAP)) &&
                         (r_unit == w_units_m1) && (r_cnt == CNT_PEN);
    assign w_err_next  = w_accept && !w_lut_valid && !w_lut_space;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_unit  <= 2'd0;
            r_idx   <= 3'd0;
            r_ready <= 1'b0;
            r_morse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_unit  <= w_unit_next;
            r_idx   <= w_idx_next;
            r_ready <= (w_next_state == S_IDLE);
            r_morse <= (w_next_state == S_MARK);
            r_busy  <= (w_next_state != S_IDLE);
            r_done  <= w_done_next;
            r_err   <= w_err_next;
        end
    end

    // Code of the character in flight; only read outside IDLE.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_len <= w_lut_len;
            r_pat <= w_lut_pat;
        end
    end

    assign ready_o = r_ready;
    assign morse_o = r_morse;
    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign err_o   = r_err;

endmodule

// File: tb/tb_morse_encoder.sv
module tb_morse_encoder;

    localparam int U = 4;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       data_valid_i = 1'b0;
    logic       ready_o, morse_o, busy_o, done_o, err_o;

    int n_checks = 0;
    int n_errors = 0;

    morse_encoder #(.WORD_BITS(8), .UNIT_LIMIT(U), .UNIT_BITS(3)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .ready_o      (ready_o),
        .morse_o      (morse_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: dot/dash string for a character, " " for space, "" if unsupported.
    function automatic string code_of(input logic [7:0] c);
        string letters [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                                "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                                "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                                "-.--", "--.."};
        logic [7:0] u;
        string      s;
        int         d;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        if (u == 8'h20) return " ";
        if (u >= 8'h41 && u <= 8'h5A) return letters[int'(u) - 65];
        if (u >= 8'h30 && u <= 8'h39) begin
            d = int'(u) - 48;
            s = "";
            for (int i = 0; i < 5; i++) begin
                if (d == 0)     s = {s, "-"};
                else if (d <= 5) s = {s, (i < d) ? "." : "-"};
                else            s = {s, (i < d - 5) ? "-" : "."};
            end
            return s;
        end
`ifdef MORSE_PUNCT_EN
        if (u == 8'h2E) return ".-.-.-";
        if (u == 8'h2C) return "--..--";
        if (u == 8'h3F) return "..--..";
        if (u == 8'h2F) return "-..-.";
`endif
        return "";
    endfunction

    // Present c at a negedge where ready_o is expected, then check every
    // cycle of the expected waveform and the return to idle.
    task automatic send(input logic [7:0] c, input bit hold);
        string s;
        bit    qm[$];
        bit    qd[$];
        int    n;
        bit    bad;
        n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("ready_before_accept", ready_o, 1'b1);
        s = code_of(c);
        bad = (s.len() == 0);
        if (s == " ") begin
            for (int k = 0; k < 4 * U; k++) begin qm.push_back(1'b0); qd.push_back(k == 4 * U - 1); end
        end else if (!bad) begin
            for (int i = 0; i < s.len(); i++) begin
                n = (s[i] == 8'h2D) ? 3 * U : U;
                for (int k = 0; k < n; k++) begin qm.push_back(1'b1); qd.push_back(1'b0); end
                if (i < s.len() - 1)
                    for (int k = 0; k < U; k++) begin qm.push_back(1'b0); qd.push_back(1'b0); end
            end
            for (int k = 0; k < 3 * U; k++) begin qm.push_back(1'b0); qd.push_back(k == 3 * U - 1); end
        end
        data_i = c;
        data_valid_i = 1'b1;
        if (bad) begin
            @(negedge clk_i);
            check_eq("err_pulse", err_o, 1'b1);
            check_eq("err_morse", morse_o, 1'b0);
            check_eq("err_ready", ready_o, 1'b1);
            check_eq("err_busy", busy_o, 1'b0);
            data_valid_i = 1'b0;
        end else begin
            for (int k = 0; k < qm.size(); k++) begin
                @(negedge clk_i);
                check_eq($sformatf("morse_%0h_%0d", c, k), morse_o, qm[k]);
                check_eq($sformatf("done_%0h_%0d", c, k), done_o, qd[k]);
                check_eq("busy_in_char", busy_o, 1'b1);
                check_eq("ready_in_char", ready_o, 1'b0);
                check_eq("err_in_char", err_o, 1'b0);
                if (k == 0) data_valid_i = hold;
            end
        end
        @(negedge clk_i);
        check_eq("ready_after", ready_o, 1'b1);
        check_eq("busy_after", busy_o, 1'b0);
        check_eq("morse_after", morse_o, 1'b0);
        check_eq("done_after", done_o, 1'b0);
        check_eq("err_after", err_o, 1'b0);
    endtask

    initial begin
        int  dones;
        logic [7:0] c;
        bit  h;
        // Reset state
        repeat (2) @(negedge clk_i);
        check_eq("rst_ready", ready_o, 1'b0);
        check_eq("rst_morse", morse_o, 1'b0);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_done", done_o, 1'b0);
        check_eq("rst_err", err_o, 1'b0);
        reset_i = 1'b0;
        @(negedge clk_i);
        check_eq("first_idle_ready", ready_o, 1'b1);

        // Directed cases
        send(8'h45, 1'b0);           // E
        send(8'h61, 1'b0);           // a
        send(8'h53, 1'b1);           // S O S streamed with valid held
        send(8'h4F, 1'b1);
        send(8'h53, 1'b0);
        send(8'h20, 1'b0);           // word gap
        send(8'h23, 1'b0);           // unsupported
        send(8'h3F, 1'b0);           // ? (config dependent)

        // Reset in the middle of the first dash of '0'
        data_i = 8'h30;
        data_valid_i = 1'b1;
        @(negedge clk_i);
        data_valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check_eq("mid_dash_morse", morse_o, 1'b1);
        #2 reset_i = 1'b1;
        #1;
        check_eq("async_rst_morse", morse_o, 1'b0);
        check_eq("async_rst_busy", busy_o, 1'b0);
        check_eq("async_rst_ready", ready_o, 1'b0);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        check_eq("post_rst_ready", ready_o, 1'b1);
        dones = 0;
        for (int k = 0; k < 16 * U; k++) begin
            @(negedge clk_i);
            if (done_o || morse_o || busy_o) dones++;
        end
        check_eq("post_rst_quiet", dones, 0);
        send(8'h54, 1'b0);           // T

        // Randomized characters in the printable range
        for (int i = 0; i < 30; i++) begin
            c = 8'($urandom_range(32, 126));
            h = (code_of(c).len() != 0) && ($urandom_range(0, 1) == 1);
            send(c, h);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
